// File: rtl/wb_intercon_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_intercon_pkg : shared types, J1 memory map and address decode
// Revision 1.0
// ------------------------------------------------------------------
package wb_intercon_pkg;

  localparam int N_SLAVES_MAX = 8;
  localparam int AW_MAX       = 32;

  // One extra code above the last real slave selects the internal error slave
  typedef logic [$clog2(N_SLAVES_MAX+1)-1:0] slv_idx_t;
  typedef logic [N_SLAVES_MAX*AW_MAX-1:0]    dec_tab_t;

  localparam int J1_N_SLAVES = 5;
  localparam int J1_AW       = 16;

  localparam logic [J1_N_SLAVES*J1_AW-1:0] J1_SLV_BASE =
    {16'h7000, 16'h6000, 16'h5000, 16'h4000, 16'h0000};
  localparam logic [J1_N_SLAVES*J1_AW-1:0] J1_SLV_MASK =
    {16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'hE000};

  // Lowest-index hit wins; no hit returns n (the error slave)
  function automatic slv_idx_t decode(input logic [AW_MAX-1:0] adr,
                                      input dec_tab_t base,
                                      input dec_tab_t mask,
                                      input int n);
    slv_idx_t idx;
    idx = slv_idx_t'(n);
    for (int i = N_SLAVES_MAX-1; i >= 0; i--) begin
      if (i < n && ((adr & mask[i*AW_MAX +: AW_MAX]) == base[i*AW_MAX +: AW_MAX]))
        idx = slv_idx_t'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_intercon_pipe_if.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_intercon_pipe_if : master-side and slave-side Wishbone B4 signals
// Revision 1.0
// ------------------------------------------------------------------
interface wb_intercon_pipe_if #(
  parameter int N_SLAVES = 5,
  parameter int AW       = 16,
  parameter int DW       = 16
) ();

  logic                   m_cyc;
  logic                   m_stb;
  logic                   m_we;
  logic [AW-1:0]          m_adr;
  logic [DW-1:0]          m_dat_o;
  logic                   m_stall;
  logic                   m_ack;
  logic                   m_err;
  logic [DW-1:0]          m_dat_i;

  logic [AW-1:0]          s_adr;
  logic                   s_we;
  logic [DW-1:0]          s_dat_i;
  logic [N_SLAVES-1:0]    s_cyc;
  logic [N_SLAVES-1:0]    s_stb;
  logic [N_SLAVES-1:0]    s_stall;
  logic [N_SLAVES-1:0]    s_ack;
  logic [N_SLAVES-1:0]    s_err;
  logic [N_SLAVES*DW-1:0] s_dat_o;

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_dat_o,
    input  m_stall, m_ack, m_err, m_dat_i
  );

  modport slave (
    input  s_adr, s_we, s_dat_i, s_cyc, s_stb,
    output s_stall, s_ack, s_err, s_dat_o
  );

  modport intercon (
    input  m_cyc, m_stb, m_we, m_adr, m_dat_o,
    output m_stall, m_ack, m_err, m_dat_i,
    output s_adr, s_we, s_dat_i, s_cyc, s_stb,
    input  s_stall, s_ack, s_err, s_dat_o
  );

endinterface
`default_nettype wire

// File: rtl/wb_resp_tracker.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_resp_tracker : outstanding-request count, owner, timeout, error slave
// Revision 1.0
// ------------------------------------------------------------------
module wb_resp_tracker
  import wb_intercon_pkg::*;
#(
  parameter int N_SLAVES = 5,
  parameter int MAX_OUT  = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     m_cyc,
  input  logic     accept,
  input  slv_idx_t target,
  input  logic     resp,
  output logic     blocked,
  output logic     busy,
  output slv_idx_t cur,
  output logic     err_pend,
  output logic     timeout_err
);

  localparam int       CW      = $clog2(MAX_OUT+1);
  localparam int       TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;
  localparam slv_idx_t INT_SLV = slv_idx_t'(N_SLAVES);

  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_timer;
  slv_idx_t      r_cur;
  logic          r_err_pend;

  assign busy     = (r_cnt != '0);
  assign cur      = r_cur;
  assign err_pend = r_err_pend;

  // Fires on the cycle the idle count would reach TIMEOUT
  assign timeout_err = (TIMEOUT != 0) && !rst && m_cyc && busy && !resp &&
                       (r_timer == TW'(TIMEOUT-1));

  // Switching slaves waits for a full drain so responses stay in order
  assign blocked = (r_cnt == CW'(MAX_OUT)) || (busy && (target != r_cur)) || timeout_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_cur      <= '0;
      r_timer    <= '0;
      r_err_pend <= 1'b0;
    end else if (!m_cyc) begin
      r_cnt      <= '0;
      r_timer    <= '0;
      r_err_pend <= 1'b0;
    end else begin
      if (accept)
        r_cur <= target;
      r_err_pend <= accept && (target == INT_SLV);

      if (timeout_err)
        r_cnt <= '0;
      else if (accept && !resp)
        r_cnt <= r_cnt + 1'b1;
      else if (!accept && resp)
        r_cnt <= r_cnt - 1'b1;

      // Restarting on accept measures the timeout from the most recent activity
      if (!busy || resp || accept || timeout_err)
        r_timer <= '0;
      else
        r_timer <= r_timer + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_intercon_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// wb_intercon_pipe : pipelined Wishbone single-master N-slave interconnect
// Revision 1.0
// ------------------------------------------------------------------
module wb_intercon_pipe
  import wb_intercon_pkg::*;
#(
  parameter int                      N_SLAVES = J1_N_SLAVES,
  parameter int                      AW       = J1_AW,
  parameter int                      DW       = 16,
  parameter int                      MAX_OUT  = 4,
  parameter int                      TIMEOUT  = 255,
  parameter logic [N_SLAVES*AW-1:0]  SLV_BASE = J1_SLV_BASE,
  parameter logic [N_SLAVES*AW-1:0]  SLV_MASK = J1_SLV_MASK
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_intercon_pipe_if.intercon bus
);

  localparam slv_idx_t INT_SLV = slv_idx_t'(N_SLAVES);

  dec_tab_t      w_base;
  dec_tab_t      w_mask;
  slv_idx_t      w_target;
  slv_idx_t      w_cur;
  logic          w_blocked;
  logic          w_busy;
  logic          w_err_pend;
  logic          w_timeout_err;
  logic          w_req;
  logic          w_tgt_stall;
  logic          w_stall;
  logic          w_accept;
  logic          w_resp_sel;
  logic          w_cur_ack;
  logic          w_cur_err;
  logic [DW-1:0] w_cur_dat;
  logic          w_ack;
  logic          w_err;

  always_comb begin
    w_base = '0;
    w_mask = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      w_base[i*AW_MAX +: AW_MAX] = AW_MAX'(SLV_BASE[i*AW +: AW]);
      w_mask[i*AW_MAX +: AW_MAX] = AW_MAX'(SLV_MASK[i*AW +: AW]);
    end
  end

  assign w_target = decode(AW_MAX'(bus.m_adr), w_base, w_mask, N_SLAVES);

  always_comb begin
    w_tgt_stall = 1'b0;
    w_cur_ack   = 1'b0;
    w_cur_err   = 1'b0;
    w_cur_dat   = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (w_target == slv_idx_t'(i))
        w_tgt_stall = bus.s_stall[i];
      if (w_cur == slv_idx_t'(i)) begin
        w_cur_ack = bus.s_ack[i];
        w_cur_err = bus.s_err[i];
        w_cur_dat = bus.s_dat_o[i*DW +: DW];
      end
    end
  end

  assign w_req      = !rst && bus.m_cyc && bus.m_stb;
  assign w_stall    = w_req && (w_blocked || w_tgt_stall);
  assign w_accept   = w_req && !w_stall;
  assign w_resp_sel = !rst && bus.m_cyc && w_busy;
  assign w_ack      = w_resp_sel && w_cur_ack;
  assign w_err      = w_resp_sel && (w_cur_err || ((w_cur == INT_SLV) && w_err_pend));

  wb_resp_tracker #(
    .N_SLAVES (N_SLAVES),
    .MAX_OUT  (MAX_OUT),
    .TIMEOUT  (TIMEOUT)
  ) u_trk (
    .clk         (clk),
    .rst         (rst),
    .m_cyc       (bus.m_cyc),
    .accept      (w_accept),
    .target      (w_target),
    .resp        (w_ack || w_err),
    .blocked     (w_blocked),
    .busy        (w_busy),
    .cur         (w_cur),
    .err_pend    (w_err_pend),
    .timeout_err (w_timeout_err)
  );

  assign bus.m_stall = w_stall;
  assign bus.m_ack   = w_ack;
  assign bus.m_err   = w_err || w_timeout_err;
  assign bus.m_dat_i = w_resp_sel ? w_cur_dat : '0;

  assign bus.s_adr   = bus.m_adr;
  assign bus.s_we    = bus.m_we;
  assign bus.s_dat_i = bus.m_dat_o;

  // The owner's cycle is dropped on the timeout cycle so it sees the abort
  generate
    for (genvar i = 0; i < N_SLAVES; i++) begin : g_port
      assign bus.s_stb[i] = w_req && (w_target == slv_idx_t'(i)) && !w_blocked;
      assign bus.s_cyc[i] = !rst && bus.m_cyc &&
                            (((w_target == slv_idx_t'(i)) && bus.m_stb) ||
                             (w_busy && (w_cur == slv_idx_t'(i)))) &&
                            !(w_timeout_err && (w_cur == slv_idx_t'(i)));
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_intercon_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_wb_intercon_pipe : directed self-checking bench for wb_intercon_pipe
// Revision 1.0
// ------------------------------------------------------------------
module tb_wb_intercon_pipe;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_intercon_pipe_if #(.N_SLAVES(5), .AW(16), .DW(16)) bus ();

  wb_intercon_pipe #(
    .N_SLAVES (5),
    .AW       (16),
    .DW       (16),
    .MAX_OUT  (4),
    .TIMEOUT  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.m_cyc   = 1'b0;
    bus.m_stb   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_adr   = '0;
    bus.m_dat_o = '0;
    bus.s_stall = '0;
    bus.s_ack   = '0;
    bus.s_err   = '0;
    bus.s_dat_o = '0;
  endtask

  task automatic req(input logic [15:0] adr);
    bus.m_cyc = 1'b1;
    bus.m_stb = 1'b1;
    bus.m_adr = adr;
  endtask

  task automatic sdat(input int idx, input logic [15:0] d);
    bus.s_dat_o = '0;
    bus.s_dat_o[idx*16 +: 16] = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();

    // outputs held quiet during reset, address still passes through
    req(16'h0010);
    bus.m_dat_o = 16'h1234;
    bus.s_ack   = '1;
    bus.s_err   = '1;
    bus.s_dat_o = {5{16'hA5A5}};
    settle();
    check("rst_s_stb",   bus.s_stb,   32'h0);
    check("rst_s_cyc",   bus.s_cyc,   32'h0);
    check("rst_m_stall", bus.m_stall, 32'h0);
    check("rst_m_ack",   bus.m_ack,   32'h0);
    check("rst_m_err",   bus.m_err,   32'h0);
    check("rst_m_dat_i", bus.m_dat_i, 32'h0);
    check("rst_s_adr",   bus.s_adr,   32'h0010);
    check("rst_s_dat_i", bus.s_dat_i, 32'h1234);
    tick();
    rst = 1'b0;
    idle();

    // single read from RAM
    tick(); req(16'h0010); settle();
    check("t1_s_stb",   bus.s_stb,   32'h01);
    check("t1_s_cyc",   bus.s_cyc,   32'h01);
    check("t1_m_stall", bus.m_stall, 32'h0);
    tick(); bus.m_stb = 1'b0; bus.s_ack = 5'b00001; sdat(0, 16'hBEEF); settle();
    check("t1_m_ack",   bus.m_ack,   32'h1);
    check("t1_m_dat_i", bus.m_dat_i, 32'hBEEF);
    check("t1_m_err",   bus.m_err,   32'h0);
    tick(); bus.s_ack = '0; settle();
    check("t1_ack_done", bus.m_ack,  32'h0);
    check("t1_cyc_done", bus.s_cyc,  32'h0);
    tick(); idle();

    // four in flight to slave 1, fifth stalls until the first ack
    for (int k = 0; k < 4; k++) begin
      tick(); req(16'(16'h4000 + k)); settle();
      check("t2_stall_fill", bus.m_stall, 32'h0);
      check("t2_stb_fill",   bus.s_stb,   32'h02);
    end
    tick(); req(16'h4004); bus.s_ack = 5'b00010; sdat(1, 16'h1000); settle();
    check("t2_stall_full", bus.m_stall, 32'h1);
    check("t2_stb_full",   bus.s_stb,   32'h0);
    check("t2_ack0",       bus.m_ack,   32'h1);
    check("t2_dat0",       bus.m_dat_i, 32'h1000);
    tick(); sdat(1, 16'h1001); settle();
    check("t2_stall_free", bus.m_stall, 32'h0);
    check("t2_stb_free",   bus.s_stb,   32'h02);
    check("t2_ack1",       bus.m_ack,   32'h1);
    check("t2_dat1",       bus.m_dat_i, 32'h1001);
    for (int k = 2; k < 5; k++) begin
      tick(); bus.m_stb = 1'b0; sdat(1, 16'(16'h1000 + k)); settle();
      check("t2_ack_drain", bus.m_ack,   32'h1);
      check("t2_dat_drain", bus.m_dat_i, 32'(16'h1000 + k));
    end
    tick(); bus.s_ack = '0; settle();
    check("t2_ack_done", bus.m_ack, 32'h0);
    check("t2_cyc_done", bus.s_cyc, 32'h0);
    tick(); idle();

    // slave change waits for drain, no extra bubble
    tick(); req(16'h0000); settle();
    check("t3_stall_first", bus.m_stall, 32'h0);
    tick(); req(16'h5000); settle();
    check("t3_stall_a", bus.m_stall, 32'h1);
    check("t3_stb_a",   bus.s_stb,   32'h0);
    check("t3_cyc_a",   bus.s_cyc,   32'h05);
    tick(); bus.s_ack = 5'b00001; sdat(0, 16'h0A0A); settle();
    check("t3_ack0",    bus.m_ack,   32'h1);
    check("t3_dat0",    bus.m_dat_i, 32'h0A0A);
    check("t3_stall_b", bus.m_stall, 32'h1);
    check("t3_stb_b",   bus.s_stb,   32'h0);
    tick(); bus.s_ack = '0; settle();
    check("t3_stall_c", bus.m_stall, 32'h0);
    check("t3_stb_c",   bus.s_stb,   32'h04);
    tick(); bus.m_stb = 1'b0; bus.s_ack = 5'b00100; sdat(2, 16'h2222); settle();
    check("t3_ack2", bus.m_ack,   32'h1);
    check("t3_dat2", bus.m_dat_i, 32'h2222);
    tick(); settle();
    check("t3_drop_idle_ack", bus.m_ack, 32'h0);
    tick(); idle();

    // unmapped accesses, back to back
    tick(); req(16'h8000); settle();
    check("t4_stb",   bus.s_stb,   32'h0);
    check("t4_cyc",   bus.s_cyc,   32'h0);
    check("t4_stall", bus.m_stall, 32'h0);
    check("t4_err_early", bus.m_err, 32'h0);
    tick(); req(16'h9000); settle();
    check("t4_stall_b", bus.m_stall, 32'h0);
    check("t4_stb_b",   bus.s_stb,   32'h0);
    check("t4_err_a",   bus.m_err,   32'h1);
    check("t4_ack_a",   bus.m_ack,   32'h0);
    tick(); bus.m_stb = 1'b0; settle();
    check("t4_err_b", bus.m_err, 32'h1);
    check("t4_ack_b", bus.m_ack, 32'h0);
    tick(); settle();
    check("t4_err_done", bus.m_err, 32'h0);
    tick(); idle();

    // slave 3 never answers
    tick(); req(16'h6000); settle();
    check("t5_stb", bus.s_stb, 32'h08);
    for (int k = 1; k < 8; k++) begin
      tick(); bus.m_stb = 1'b0; settle();
      check("t5_wait_err", bus.m_err, 32'h0);
      check("t5_wait_cyc", bus.s_cyc, 32'h08);
    end
    tick(); settle();
    check("t5_timeout_err", bus.m_err, 32'h1);
    check("t5_timeout_cyc", bus.s_cyc, 32'h0);
    tick(); bus.s_ack = 5'b01000; settle();
    check("t5_late_ack", bus.m_ack, 32'h0);
    check("t5_late_err", bus.m_err, 32'h0);
    tick(); idle();

    // reset with two outstanding, then a clean access to slave 4
    tick(); req(16'h4000); settle();
    check("t6_stall_a", bus.m_stall, 32'h0);
    tick(); req(16'h4001); settle();
    check("t6_stall_b", bus.m_stall, 32'h0);
    tick(); rst = 1'b1; req(16'h4002); bus.s_ack = 5'b00010; sdat(1, 16'hDEAD); settle();
    check("t6_rst_s_cyc",   bus.s_cyc,   32'h0);
    check("t6_rst_s_stb",   bus.s_stb,   32'h0);
    check("t6_rst_m_ack",   bus.m_ack,   32'h0);
    check("t6_rst_m_err",   bus.m_err,   32'h0);
    check("t6_rst_m_stall", bus.m_stall, 32'h0);
    check("t6_rst_m_dat_i", bus.m_dat_i, 32'h0);
    tick(); rst = 1'b0; req(16'h7000); settle();
    check("t6_stall_new", bus.m_stall, 32'h0);
    check("t6_stb_new",   bus.s_stb,   32'h10);
    check("t6_stale_ack", bus.m_ack,   32'h0);
    tick(); bus.m_stb = 1'b0; bus.s_ack = 5'b10000; sdat(4, 16'h4444); settle();
    check("t6_ack4", bus.m_ack,   32'h1);
    check("t6_dat4", bus.m_dat_i, 32'h4444);
    tick(); bus.s_ack = '0; settle();
    check("t6_ack_done", bus.m_ack, 32'h0);
    check("t6_cyc_done", bus.s_cyc, 32'h0);
    tick(); idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_intercon_pipe.md
# wb_intercon_pipe

Parametrised single-master Wishbone (pipelined, B4) interconnect for the J1 data bus, the successor to the fixed five-slave decoder. Routes one master to N_SLAVES slaves using per-slave base/mask decode. Tracks up to MAX_OUT outstanding requests so acks and read data are steered to the slave that owns them. Adds an internal error slave for unmapped addresses and a response timeout.

## Interface
- N_SLAVES, 5, number of slave ports (1..8)
- AW, 16, address width
- DW, 16, data width
- MAX_OUT, 4, maximum outstanding requests (1..15)
- TIMEOUT, 255, cycles without a response before abort; 0 disables
- SLV_BASE, {16'h7000,16'h6000,16'h5000,16'h4000,16'h0000}, N_SLAVES×AW base addresses, slave 0 in the LSBs
- SLV_MASK, {16'hF800,16'hF800,16'hF800,16'hF800,16'hE000}, N_SLAVES×AW decode masks
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- m_cyc, m_stb, m_we  in  1 each  master cycle, strobe and write enable
- m_adr  in  AW  master address
- m_dat_o  in  DW  master write data
- m_stall  out  1  master stall
- m_ack, m_err  out  1 each  master response
- m_dat_i  out  DW  master read data
- s_adr  out  AW  broadcast address
- s_we  out  1  broadcast write enable
- s_dat_i  out  DW  broadcast write data
- s_cyc, s_stb  out  N_SLAVES  per-slave cycle and strobe
- s_stall, s_ack, s_err  in  N_SLAVES  per-slave stall and responses
- s_dat_o  in  N_SLAVES×DW  per-slave read data

## Operation
- Decode: hit[i] = ((m_adr & MASK[i]) == BASE[i]). The lowest-index hit wins. If no slave hits, the target is the internal error slave (index N_SLAVES).
- State registers:
  - cnt: outstanding requests, 0..MAX_OUT
  - cur: index of the slave owning the outstanding requests
  - timer
  - err_pend: internal error-slave response due
- blocked = (cnt==MAX_OUT) | (cnt!=0 & target!=cur). Traffic to a new slave waits for the outstanding requests to drain, so responses always return in order.
- m_stall = m_cyc & m_stb & (blocked | s_stall[target]). The internal slave never stalls.
- Request gating:
  - s_stb[i] = m_cyc & m_stb & (target==i) & !blocked
  - s_cyc[i] = m_cyc & ((target==i & m_stb) | (cnt!=0 & cur==i))
- accept = m_cyc & m_stb & !m_stall. On accept, cur <= target.
- Response path, only while cnt!=0:
  - m_ack = s_ack[cur]
  - m_err = s_err[cur]
  - m_dat_i = s_dat_o[cur]; m_dat_i = 0 when no response is selected.
  - Slave responses while cnt==0, or from a slave other than cur, are dropped.
- Internal error slave: an accepted unmapped request sets err_pend. m_err pulses the next cycle. Back-to-back unmapped requests give consecutive m_err pulses.
- Counter update: cnt += accept − response. If accept and response occur in the same cycle, cnt is unchanged.
- Timeout:
  - timer increments while cnt!=0 and no response arrives. It clears on any response or when cnt==0.
  - When timer reaches TIMEOUT: m_err pulses once, cnt <= 0, and s_cyc[cur] is forced low that cycle. Late responses are dropped.
- Master abort: if m_cyc falls while cnt!=0, then cnt, timer and err_pend clear next cycle. No response is forwarded after m_cyc falls.
- Reset:
  - cnt=0, cur=0, timer=0, err_pend=0.
  - While rst is high: s_cyc, s_stb, m_ack, m_err and m_stall are 0, and m_dat_i is 0.
  - s_adr, s_we and s_dat_i are pass-through at all times.
  - Reset asserted mid-transfer discards all outstanding requests.

## Timing
- The request path is combinational: s_stb is asserted in the same cycle as m_stb.
- The response path is combinational from s_ack/s_err/s_dat_o to the master, selected by the registered cur.
- Throughput is 1 request per cycle to one slave, up to MAX_OUT in flight.
- Changing slave costs the drain time of the outstanding requests, with no extra bubble after the last response.
- Unmapped access: m_err one cycle after accept.
- Timeout error: TIMEOUT cycles after the last accept or response, with no response received.

## Structure
- Package wb_intercon_pkg:
  - a slave-index typedef sized $clog2(N_SLAVES+1)
  - a decode function (address, base, mask arrays → index)
  - default base/mask constants for the J1 memory map
- Sub-module wb_resp_tracker holds cnt, cur, timer and err_pend. It outputs blocked, cur and timeout_err. The top level holds the decode and steering.

## Test plan
- Read RAM at 16'h0010, slave 0 acks one cycle later with 16'hBEEF → m_ack=1, m_dat_i=16'hBEEF, cnt returns to 0.
- Four back-to-back reads to 16'h4000..4003, slave 1 delays its acks by 3 cycles → no m_stall through the 4th request; a 5th request stalls until the first ack.
- Read 16'h0000 then immediately 16'h5000 → the second request stalls until slave 0 acks; it then reaches s_stb[2] in the cycle after that ack.
- Access to 16'h8000 (unmapped) → no s_stb asserted, m_err=1 exactly one cycle later, m_ack=0.
- Slave 3 never acks, TIMEOUT=8 → m_err after 8 cycles, s_cyc[3] low for that cycle, a later s_ack[3] is ignored.
- rst asserted with 2 requests outstanding → all outputs 0, cnt=0; the next access to slave 4 proceeds with no stale ack.
